// File: rtl/gshare_pkg.sv
// Shared types and counter helpers for the gshare predictor.
// The in-flight entry uses fixed maximum field widths so any legal config fits.
package gshare_pkg;

   localparam int GS_MAX_W   = 16;
   localparam int GS_CTR_MAX = 8;

   typedef struct packed {
      logic [GS_MAX_W-1:0] idx;
      logic [GS_MAX_W-1:0] ghr;
      logic                pred;
   } infl_entry_t;

   function automatic logic [GS_CTR_MAX-1:0] ctr_reset_val(
      input int ctr_w
   );
      return GS_CTR_MAX'((1 << (ctr_w - 1)) - 1);
   endfunction

   function automatic logic [GS_CTR_MAX-1:0] sat_inc(
      input logic [GS_CTR_MAX-1:0] c,
      input int                    ctr_w
   );
      logic [GS_CTR_MAX-1:0] w_max;
      w_max = GS_CTR_MAX'((1 << ctr_w) - 1);
      return (c == w_max) ? c : c + GS_CTR_MAX'(1);
   endfunction

   function automatic logic [GS_CTR_MAX-1:0] sat_dec(
      input logic [GS_CTR_MAX-1:0] c
   );
      return (c == '0) ? c : c - GS_CTR_MAX'(1);
   endfunction

endpackage

// File: rtl/gshare_inflight_fifo.sv
// Ordered queue of in-flight branch snapshots awaiting resolution.
// Wrap-bit pointers: full when wrap bits differ and index bits match.
module gshare_inflight_fifo
   import gshare_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic        i_clear,
   input  infl_entry_t i_wdata,
   output infl_entry_t o_rdata,
   output logic        o_full,
   output logic        o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] r_wr;
   logic [AW:0] r_rd;
   infl_entry_t r_mem [DEPTH];
   logic        w_wen;

   assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_empty = (r_wr == r_rd);
   assign o_rdata = r_mem[r_rd[AW-1:0]];
   assign w_wen   = i_push & ~o_full & ~i_clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (i_clear) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_wen) r_wr <= r_wr + PTR_ONE;
         if (i_pop && !o_empty) r_rd <= r_rd + PTR_ONE;
      end
   end

   // payload needs no reset: the pointers gate every read
   always_ff @(posedge clk) begin
      if (w_wen) r_mem[r_wr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/gshare_bp_param.sv
// Parametrised gshare direction predictor with speculative GHR and repair.
// Define GSHARE_STATS_EN to add the resolve/mispredict statistics ports.
module gshare_bp_param
   import gshare_pkg::*;
#(
   parameter int PC_IDX_W   = 5,
   parameter int HIST_W     = 5,
   parameter int CTR_W      = 2,
   parameter int INFL_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PC_IDX_W-1:0] br_pc_lo,
   input  logic                br_detect_if,
   input  logic                br_detect_id,
   input  logic                br_stall,
   input  logic                br_actual_taken,
   output logic                predict_br_taken,
   output logic                br_mispredict,
   output logic                inflight_full
`ifdef GSHARE_STATS_EN
   ,
   output logic [31:0]         stat_pred_cnt,
   output logic [31:0]         stat_mispred_cnt
`endif
);

   localparam int PHT_N = 2 ** PC_IDX_W;
   localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));

   logic [CTR_W-1:0]    r_pht [PHT_N];
   logic [HIST_W-1:0]   r_ghr;
   logic                r_mispredict;

   infl_entry_t         w_head;
   infl_entry_t         w_entry;
   logic                w_full;
   logic                w_empty;
   logic                w_pred;
   logic                w_push;
   logic                w_pop;
   logic                w_mis;
   logic [PC_IDX_W-1:0] w_idx;
   logic [PC_IDX_W-1:0] w_head_idx;
   logic [HIST_W-1:0]   w_ghr_head;
   logic [HIST_W-1:0]   w_ghr_push;
   logic [HIST_W-1:0]   w_ghr_fix;
   logic [CTR_W-1:0]    w_ctr_old;
   logic [CTR_W-1:0]    w_ctr_new;

   assign w_idx      = br_pc_lo ^ PC_IDX_W'(r_ghr);
   assign w_pred     = r_pht[w_idx][CTR_W-1];
   assign w_push     = br_detect_if & ~br_stall & ~w_full;
   assign w_pop      = br_detect_id & ~br_stall & ~w_empty;
   assign w_mis      = w_pop & (br_actual_taken != w_head.pred);
   assign w_head_idx = w_head.idx[PC_IDX_W-1:0];
   assign w_ghr_head = w_head.ghr[HIST_W-1:0];

   assign w_entry.idx  = GS_MAX_W'(w_idx);
   assign w_entry.ghr  = GS_MAX_W'(r_ghr);
   assign w_entry.pred = w_pred;

   assign w_ctr_old = r_pht[w_head_idx];
   assign w_ctr_new = br_actual_taken ?
      CTR_W'(sat_inc(GS_CTR_MAX'(w_ctr_old), CTR_W)) :
      CTR_W'(sat_dec(GS_CTR_MAX'(w_ctr_old)));

   generate
      if (HIST_W == 1) begin : g_hist1
         assign w_ghr_push = w_pred;
         assign w_ghr_fix  = br_actual_taken;
      end else begin : g_histn
         assign w_ghr_push = {r_ghr[HIST_W-2:0], w_pred};
         assign w_ghr_fix  = {w_ghr_head[HIST_W-2:0], br_actual_taken};
      end
   endgenerate

   // a mispredict flushes the queue, so any same-cycle push is dropped
   gshare_inflight_fifo #(
      .DEPTH (INFL_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push & ~w_mis),
      .i_pop   (w_pop),
      .i_clear (w_mis),
      .i_wdata (w_entry),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHT_N; i++) r_pht[i] <= CTR_RST;
         r_ghr        <= '0;
         r_mispredict <= 1'b0;
      end else begin
         r_mispredict <= w_mis;
         if (w_pop) r_pht[w_head_idx] <= w_ctr_new;
         if (w_mis) r_ghr <= w_ghr_fix;
         else if (w_push) r_ghr <= w_ghr_push;
      end
   end

   assign predict_br_taken = w_pred & br_detect_if & ~w_full;
   assign br_mispredict    = r_mispredict;
   assign inflight_full    = w_full;

`ifdef GSHARE_STATS_EN
   logic [31:0] r_stat_pred;
   logic [31:0] r_stat_mis;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_pred <= '0;
         r_stat_mis  <= '0;
      end else begin
         if (w_pop) r_stat_pred <= r_stat_pred + 32'd1;
         if (w_mis) r_stat_mis  <= r_stat_mis + 32'd1;
      end
   end

   assign stat_pred_cnt    = r_stat_pred;
   assign stat_mispred_cnt = r_stat_mis;
`endif

endmodule
